// File: rtl/cla_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial lookahead subtractor.
package cla_sub_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_sub_state_t;

  function automatic int unsigned nslice(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cls4.sv
// Combinational 4-bit carry-lookahead subtract slice: d = a - b - bin.
module cls4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] bb;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Subtraction as a + ~b + ~bin, so carry-in is the inverted borrow.
  assign bb = ~b;
  assign g  = a & bb;
  assign p  = a ^ bb;

  assign c[0] = ~bin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign d    = p ^ c[3:0];
  assign bout = ~c[4];

endmodule

// File: rtl/cla_sub_serial.sv
// Digit-serial WIDTH-bit subtractor, four bits per cycle behind valid/ready.
// Optional signed-overflow flag enabled by defining CLA_SUB_OVF_EN.
module cla_sub_serial
  import cla_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int unsigned NSLICE = nslice(WIDTH);
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  cla_sub_state_t   state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [IDX_W-1:0] idx_q;
  logic             borrow_q;
  logic             b_out_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [SLICE_W-1:0] slice_d;
  logic               slice_bout;

  // Operands shift right each RUN cycle so the active slice is always the low nibble.
  cls4 u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .bin  (borrow_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      b_out_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            borrow_q   <= b_in;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q      <= a_q >> SLICE_W;
          b_q      <= b_q >> SLICE_W;
          borrow_q <= slice_bout;
          // Result fills from the top so slice 0 lands in bits 3:0 after the last shift.
          diff_q   <= WIDTH'({slice_d, diff_q} >> SLICE_W);
          if (idx_q == LAST_IDX) begin
            idx_q       <= '0;
            b_out_q     <= slice_bout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef CLA_SUB_OVF_EN
  logic ovf_q;

  // At the last slice the low nibbles hold the operand MSBs and slice_d[3] is the result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if ((state_q == RUN) && (idx_q == LAST_IDX)) begin
      ovf_q <= (a_q[SLICE_W-1] ^ b_q[SLICE_W-1]) & (slice_d[SLICE_W-1] ^ a_q[SLICE_W-1]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign b_out     = b_out_q;

endmodule

// File: tb/tb_cla_sub_serial.sv
// Directed plus random checks of cla_sub_serial against an arithmetic reference model.
module tb_cla_sub_serial;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         b_out;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  cla_sub_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; hold keeps out_ready low that many cycles while new operands are offered.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic op_bin, input int hold);
    logic [31:0] e_diff;
    logic        e_bout;
    logic        e_ovf;
    int          lat;
    bit          seen;
    e_diff = op_a - op_b - 32'(op_bin);
    e_bout = ({1'b0, op_a} < ({1'b0, op_b} + 33'(op_bin)));
`ifdef CLA_SUB_OVF_EN
    e_ovf = (op_a[31] != op_b[31]) && (e_diff[31] != op_a[31]);
`else
    e_ovf = 1'b0;
`endif
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a        = op_a;
    b        = op_b;
    b_in     = op_bin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    b_in     = 1'($urandom_range(0, 1));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", 32'(lat), 32'd8);
    check("diff", diff, e_diff);
    check("b_out", 32'(b_out), 32'(e_bout));
    check("ovf", 32'(ovf), 32'(e_ovf));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a        = $urandom;
      b        = $urandom;
      tick();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_diff", diff, e_diff);
      check("hold_b_out", 32'(b_out), 32'(e_bout));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_fall", 32'(out_valid), 32'd0);
    check("in_ready_rise", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    b_in      = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", diff, 32'd0);
    check("rst_b_out", 32'(b_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
    run_op(32'h0001_0000, 32'h0000_0001, 1'b1, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 5);

    // Reset while slice 3 is the active slice.
    a        = 32'hCAFE_0000;
    b        = 32'h0000_1234;
    b_in     = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    #3 rst_n = 1'b1;
    tick();
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_diff", diff, 32'd0);
    run_op(32'd10, 32'd4, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
